// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the 8-bit accumulator CPU.
//   DEF_AW / DEF_DW : default address and data widths
//   opcode_t        : 3-bit opcode type held in ir[7:5]
//   OP_*            : opcode encodings
package cpu_pkg;

   localparam int DEF_AW = 5;
   localparam int DEF_DW = 8;

   typedef logic [2:0] opcode_t;

   localparam opcode_t OP_HLT = 3'd0;
   localparam opcode_t OP_SKZ = 3'd1;
   localparam opcode_t OP_ADD = 3'd2;
   localparam opcode_t OP_AND = 3'd3;
   localparam opcode_t OP_XOR = 3'd4;
   localparam opcode_t OP_LDA = 3'd5;
   localparam opcode_t OP_STO = 3'd6;
   localparam opcode_t OP_JMP = 3'd7;

endpackage

// File: rtl/cpu_alu.sv
// cpu_alu: combinational ALU of the accumulator CPU.
//   opcode : current instruction opcode (ir[7:5])
//   ac     : accumulator value
//   b      : memory read data operand
//   result : value that AC takes when ld_ac is asserted
module cpu_alu
   import cpu_pkg::*;
#(
   parameter int DW = DEF_DW
) (
   input  logic [2:0]    opcode,
   input  logic [DW-1:0] ac,
   input  logic [DW-1:0] b,
   output logic [DW-1:0] result
);

   always_comb begin
      result = ac;
      case (opcode)
         OP_ADD:  result = ac + b;   // carry out is discarded
         OP_AND:  result = ac & b;
         OP_XOR:  result = ac ^ b;
         OP_LDA:  result = b;
         default: result = ac;       // HLT/SKZ/STO/JMP leave AC untouched
      endcase
   end

endmodule

// File: rtl/cpu_datapath.sv
// cpu_datapath: PC, IR, AC and ALU of the 8-bit accumulator CPU.
//   clk, rst        : clock, asynchronous active-high reset
//   rd, wr, data_e  : memory strobes from control
//   ld_ir, ld_ac    : load IR from mem_rdata / AC from ALU result
//   ld_pc, inc_pc   : PC jump (priority) / PC increment
//   halt            : sets the sticky halted flag
//   sel             : address select (1 = PC, 0 = IR operand)
//   opcode, zero    : status back to control
//   mem_*           : memory address, strobes and write data
//   halted          : sticky halt status
//   proto_err       : sticky illegal-strobe-combination flag
//
// Strobe semantics: every strobe is a single-cycle command sampled at the
// rising edge; there is no back-pressure. The memory responds
// combinationally, so mem_rdata must be valid in the same cycle as rd and
// is consumed by ld_ir/ld_ac at the closing edge. mem_wdata is valid
// whenever mem_wdata_oe is high; a write commits when mem_wr is high at
// the edge.
module cpu_datapath
   import cpu_pkg::*;
#(
   parameter int AW = DEF_AW,
   parameter int DW = DEF_DW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          rd,
   input  logic          wr,
   input  logic          ld_ir,
   input  logic          ld_ac,
   input  logic          ld_pc,
   input  logic          inc_pc,
   input  logic          halt,
   input  logic          data_e,
   input  logic          sel,
   output logic [2:0]    opcode,
   output logic          zero,
   output logic [AW-1:0] mem_addr,
   output logic          mem_rd,
   output logic          mem_wr,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_wdata_oe,
   input  logic [DW-1:0] mem_rdata,
   output logic          halted,
   output logic          proto_err
);

   logic [AW-1:0] pc;
   logic [DW-1:0] ir;
   logic [DW-1:0] ac;
   logic [DW-1:0] alu_out;
   logic          proto_viol;

   cpu_alu #(.DW(DW)) u_alu (
      .opcode (opcode),
      .ac     (ac),
      .b      (mem_rdata),
      .result (alu_out)
   );

   assign opcode       = ir[DW-1 -: 3];
   assign zero         = (ac == '0);
   assign mem_addr     = sel ? pc : ir[AW-1:0];
   assign mem_rd       = rd & ~halted;
   assign mem_wr       = wr & data_e & ~halted;
   assign mem_wdata    = ac;
   assign mem_wdata_oe = data_e;

   // Illegal combinations are flagged but the strobes still act normally.
   assign proto_viol = (ld_pc & inc_pc) | (wr & ~data_e) | (rd & wr);

   // Register file. The halted flag is the registered value, so loads
   // issued in the same cycle as halt still take effect.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc <= '0;
         ir <= '0;
         ac <= '0;
      end else if (!halted) begin
         if (ld_ir)
            ir <= mem_rdata;
         if (ld_ac)
            ac <= alu_out;
         if (ld_pc)
            pc <= ir[AW-1:0];
         else if (inc_pc)
            pc <= pc + AW'(1);   // wraps naturally at 2**AW
      end
   end

   // Sticky status flags, cleared only by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         halted    <= 1'b0;
         proto_err <= 1'b0;
      end else begin
         if (halt)
            halted <= 1'b1;
         if (proto_viol)
            proto_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_cpu_datapath.sv
// tb_cpu_datapath: directed self-checking bench for cpu_datapath with a
// behavioural 32x8 asynchronous-read memory.
module tb_cpu_datapath;
   import cpu_pkg::*;

   localparam int AW = 5;
   localparam int DW = 8;

   // ---------------- clock / reset ----------------
   logic clk;
   logic rst;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DUT signals ----------------
   logic          rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, halt, data_e, sel;
   logic [2:0]    opcode;
   logic          zero;
   logic [AW-1:0] mem_addr;
   logic          mem_rd, mem_wr;
   logic [DW-1:0] mem_wdata;
   logic          mem_wdata_oe;
   logic [DW-1:0] mem_rdata;
   logic          halted, proto_err;

   cpu_datapath #(.AW(AW), .DW(DW)) dut (
      .clk          (clk),
      .rst          (rst),
      .rd           (rd),
      .wr           (wr),
      .ld_ir        (ld_ir),
      .ld_ac        (ld_ac),
      .ld_pc        (ld_pc),
      .inc_pc       (inc_pc),
      .halt         (halt),
      .data_e       (data_e),
      .sel          (sel),
      .opcode       (opcode),
      .zero         (zero),
      .mem_addr     (mem_addr),
      .mem_rd       (mem_rd),
      .mem_wr       (mem_wr),
      .mem_wdata    (mem_wdata),
      .mem_wdata_oe (mem_wdata_oe),
      .mem_rdata    (mem_rdata),
      .halted       (halted),
      .proto_err    (proto_err)
   );

   // Memory: combinational read; writes are applied by the step task.
   logic [DW-1:0] mem [0:31];
   assign mem_rdata = mem[mem_addr];

   // ---------------- scoreboard ----------------
   int tests_run    = 0;
   int tests_failed = 0;
   logic [7:0] exp_q [$];

   task automatic expect_val(input logic [7:0] v);
      exp_q.push_back(v);
   endtask

   task automatic check(input string tag, input logic [7:0] obs);
      logic [7:0] e;
      tests_run++;
      if (exp_q.size() == 0) begin
         tests_failed++;
         $error("FAIL %s: observed %h, no expected value queued", tag, obs);
      end else begin
         e = exp_q.pop_front();
         assert (obs === e) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, e);
         end
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic clear_strobes();
      rd = 0; wr = 0; ld_ir = 0; ld_ac = 0; ld_pc = 0;
      inc_pc = 0; halt = 0; data_e = 0;
   endtask

   // One clock: capture the memory write request, clock, apply it, then
   // leave time 1 after the edge for sampling.
   task automatic step();
      logic          w;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      #1;
      w = mem_wr; a = mem_addr; d = mem_wdata;
      @(posedge clk);
      if (w) mem[a] = d;
      #1;
      clear_strobes();
   endtask

   task automatic check_pc(input string tag, input logic [7:0] exp_pc);
      sel = 1;
      #1;
      expect_val(exp_pc);
      check(tag, 8'(mem_addr));
   endtask

   task automatic check_ac(input string tag, input logic [7:0] exp_ac);
      #1;
      expect_val(exp_ac);
      check(tag, mem_wdata);
   endtask

   task automatic fetch_at(input logic [AW-1:0] a, input logic [7:0] instr);
      mem[a] = instr;
      sel = 1; rd = 1; ld_ir = 1;
      step();
   endtask

   task automatic exec_ld_ac();
      sel = 0; rd = 1; ld_ac = 1;
      step();
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      clear_strobes();
      sel = 1;
      for (int i = 0; i < 32; i++) mem[i] = 8'h00;
      mem[0] = 8'hA3;
      rst = 1;
      #12;
      rst = 0;
      #1;

      // reset state
      expect_val(8'd0); check("rst_opcode", 8'(opcode));
      expect_val(8'd1); check("rst_zero", 8'(zero));
      expect_val(8'd0); check("rst_addr", 8'(mem_addr));
      expect_val(8'd0); check("rst_mem_rd", 8'(mem_rd));
      expect_val(8'd0); check("rst_mem_wr", 8'(mem_wr));
      expect_val(8'd0); check("rst_halted", 8'(halted));
      expect_val(8'd0); check("rst_proto", 8'(proto_err));

      // fetch from address 0
      sel = 1; rd = 1; ld_ir = 1;
      #1;
      expect_val(8'd1); check("fetch_mem_rd", 8'(mem_rd));
      step();
      sel = 0;
      #1;
      expect_val(8'd5); check("fetch_opcode", 8'(opcode));
      expect_val(8'd3); check("fetch_operand", 8'(mem_addr));
      check_pc("fetch_pc_hold", 8'd0);

      // LDA 3
      mem[3] = 8'hF0;
      exec_ld_ac();
      check_ac("lda_ac", 8'hF0);
      expect_val(8'd0); check("lda_zero", 8'(zero));

      // ADD 4 with wrap
      inc_pc = 1;
      step();
      check_pc("inc_pc_1", 8'd1);
      fetch_at(5'd1, 8'h44);
      mem[4] = 8'h20;
      exec_ld_ac();
      check_ac("add_wrap_ac", 8'h10);
      expect_val(8'd0); check("add_zero", 8'(zero));

      // XOR to zero
      mem[5] = 8'h5A;
      fetch_at(5'd1, 8'hA5);
      exec_ld_ac();
      check_ac("lda_5a", 8'h5A);
      fetch_at(5'd1, 8'h85);
      sel = 0; rd = 1; ld_ac = 1;
      #1;
      expect_val(8'd0); check("xor_zero_before", 8'(zero));
      step();
      expect_val(8'd1); check("xor_zero_after", 8'(zero));
      check_ac("xor_ac", 8'h00);

      // JMP 31 then wrap
      fetch_at(5'd1, 8'hFF);
      ld_pc = 1;
      step();
      check_pc("jmp_31", 8'd31);
      inc_pc = 1;
      step();
      check_pc("pc_wrap", 8'd0);
      expect_val(8'd0); check("proto_still_clear", 8'(proto_err));

      // ld_pc and inc_pc together
      fetch_at(5'd0, 8'hE9);
      ld_pc = 1; inc_pc = 1;
      step();
      check_pc("ldpc_priority", 8'd9);
      expect_val(8'd1); check("proto_set", 8'(proto_err));

      // store AC (0) to operand 9
      mem[9] = 8'hFF;
      sel = 0; wr = 1; data_e = 1;
      #1;
      expect_val(8'd1); check("sto_mem_wr", 8'(mem_wr));
      expect_val(8'd1); check("sto_oe", 8'(mem_wdata_oe));
      step();
      expect_val(8'h00); check("sto_mem9", mem[9]);

      // halt, then attempted loads and writes are ignored
      mem[7] = 8'h77;
      fetch_at(5'd9, 8'hA7);
      halt = 1;
      step();
      expect_val(8'd1); check("halted_set", 8'(halted));
      for (int i = 0; i < 3; i++) begin
         sel = 0; rd = 1; ld_ac = 1; inc_pc = 1; wr = 1; data_e = 1;
         #1;
         expect_val(8'd0); check("halt_mem_wr", 8'(mem_wr));
         expect_val(8'd0); check("halt_mem_rd", 8'(mem_rd));
         step();
      end
      check_pc("halt_pc", 8'd9);
      check_ac("halt_ac", 8'h00);
      expect_val(8'h77); check("halt_mem7", mem[7]);
      expect_val(8'd1); check("halted_sticky", 8'(halted));

      // asynchronous reset between clock edges
      @(negedge clk);
      #1;
      rst = 1;
      #1;
      expect_val(8'd0); check("async_halted", 8'(halted));
      expect_val(8'd0); check("async_proto", 8'(proto_err));
      expect_val(8'd0); check("async_opcode", 8'(opcode));
      expect_val(8'd0); check("async_pc", 8'(mem_addr));
      #10;
      rst = 0;

      if (exp_q.size() != 0) begin
         tests_failed++;
         $error("FAIL leftover_expected: observed %0d queued expected 0", exp_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/cpu_datapath.md
# cpu_datapath

Datapath half of the 8-bit accumulator CPU. It holds the program counter, instruction register, accumulator and ALU. It obeys the per-cycle strobes issued by `control`, drives the memory address, read and write signals, and returns `opcode` and `zero` to `control`. It sits between `control` and the 32×8 asynchronous-read program/data memory.

## Interface
- `AW`, default 5: address width; PC and IR operand field.
- `DW`, default 8: data width; IR, AC and memory word.
- `clk` input, 1: single clock; all state updates on the rising edge.
- `rst` input, 1: asynchronous, active-high reset.
- `rd` input, 1: memory read strobe from `control`.
- `wr` input, 1: memory write strobe.
- `ld_ir` input, 1: load IR from `mem_rdata`.
- `ld_ac` input, 1: load AC from the ALU result.
- `ld_pc` input, 1: load PC from `ir[AW-1:0]`.
- `inc_pc` input, 1: increment PC.
- `halt` input, 1: halt request.
- `data_e` input, 1: write-data drive enable.
- `sel` input, 1: address select; 1 selects PC, 0 selects the IR operand.
- `opcode` output, 3: `ir[7:5]`, to `control`.
- `zero` output, 1: `ac == 0`, to `control`.
- `mem_addr` output, AW: memory address.
- `mem_rd` output, 1: memory read enable.
- `mem_wr` output, 1: memory write enable.
- `mem_wdata` output, DW: write data.
- `mem_wdata_oe` output, 1: write data valid/drive.
- `mem_rdata` input, DW: combinational read data.
- `halted` output, 1: sticky halt status.
- `proto_err` output, 1: sticky protocol-violation flag.

## Operation
- Instruction format: `[7:5]` is the opcode, `[4:0]` is the operand address.
- Opcodes: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
- `mem_addr = sel ? pc : ir[4:0]` (combinational).
- `mem_rd = rd & ~halted`.
- `mem_wr = wr & data_e & ~halted`.
- `mem_wdata = ac`; `mem_wdata_oe = data_e`.
- ALU, with `b = mem_rdata`:
  - ADD: `(ac + b) mod 256`; no carry is kept.
  - AND: `ac & b`.
  - XOR: `ac ^ b`.
  - LDA: `b`.
  - All other opcodes: `ac`.
- `ld_ir`: `ir <= mem_rdata`.
- `ld_ac`: `ac <= alu_out`.
- PC update:
  - `ld_pc` has priority over `inc_pc`: `pc <= ir[4:0]`.
  - Otherwise `inc_pc` gives `pc <= pc + 1`, wrapping 31→0.
- `halted` is set on any cycle with `halt = 1`. It clears only on reset.
- While `halted = 1`: `ld_ir`, `ld_ac`, `ld_pc` and `inc_pc` are ignored, and the memory strobes are forced low.
- `proto_err` is set, and stays set until reset, on any cycle with:
  - `ld_pc & inc_pc`, or
  - `wr & ~data_e`, or
  - `rd & wr`.
- Strobes in the cycle that sets `proto_err` still execute under the rules above.

## Timing
- Reset values: pc=0, ir=0, ac=0, halted=0, proto_err=0.
- Resulting outputs after reset: `opcode` 0, `zero` 1, `mem_addr` 0 when `sel = 1`, `mem_rd` 0, `mem_wr` 0.
- Register loads take effect at the edge where the strobe is sampled high. The new value is visible on the outputs one cycle later (latency 1).
- `opcode` and `zero` are purely combinational from the IR/AC registers. `control` sees an updated opcode in the cycle after `ld_ir`.
- Memory read is combinational. `mem_rdata` must be stable before the edge that samples `ld_ir` or `ld_ac`.
- `halt` takes effect on the following cycle. Loads asserted in the same cycle as `halt` still execute.
- Reset asserted mid-instruction clears all state immediately, asynchronously, with no wait for the clock. Release is sampled at the next rising edge.

## Structure
- Package `cpu_pkg`:
  - opcode localparams `OP_HLT` … `OP_JMP`.
  - `AW`/`DW` defaults.
  - typedef `opcode_t` (3-bit).
- Sub-module `cpu_alu`: combinational; inputs opcode, ac, b; output result.
- Register file and flags stay in `cpu_datapath`.

## Test plan
- **Reset and fetch:** reset with `mem[0] = 8'hA3`; then `sel=1, rd=1, ld_ir=1` for one cycle.
  - Next cycle: `opcode = 5`, `mem_addr` with `sel=0` is 3.
- **LDA then ADD:** `mem[3] = 8'hF0`, run LDA; then `mem[4] = 8'h20`, run ADD with operand 4.
  - `ac = 8'h10` (wrapped), `zero = 0`.
- **XOR to zero:** ac=`8'h5A`, XOR with data `8'h5A`.
  - `ac = 0`, `zero = 1`, visible the cycle after `ld_ac`.
- **PC wrap and priority:** pc=31 with `inc_pc`.
  - `pc = 0`.
- **ld_pc and inc_pc together:** assert both with `ir[4:0] = 9`.
  - `pc = 9`, `proto_err = 1`.
- **Halt:** pulse `halt`, then assert `inc_pc`, `ld_ac` and `wr+data_e` for 3 cycles.
  - pc and ac are unchanged, `mem_wr = 0`, `halted = 1`.
  - Async reset clears `halted` without any clock edge.
